// File: rtl/data_mem_rw_pkg.sv
// Shared types, defaults and address helper for the data_mem_rw scratch data memory.
package data_mem_pkg;

    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_ADDR_W    = 8;
    localparam int unsigned DEF_DEPTH     = 256;
    localparam int unsigned DEF_PROT_BASE = 128;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } mem_state_e;

    // base + offset modulo 2**width; the carry out of the address adder is dropped
    function automatic logic [31:0] ea_wrap(input logic [31:0] base,
                                            input logic [31:0] offset,
                                            input int unsigned width);
        logic [63:0] sum;
        logic [63:0] mask;
        sum  = 64'(base) + 64'(offset);
        mask = (64'(1) << width) - 64'(1);
        return 32'(sum & mask);
    endfunction

endpackage

// File: rtl/data_mem_rw_if.sv
// Load/store bus between the datapath (master) and the data memory (slave).
interface data_mem_rw_if
    import data_mem_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
);
    logic              read_en;
    logic              write_en;
    logic [ADDR_W-1:0] base_address;
    logic [ADDR_W-1:0] offset_address;
    logic [DATA_W-1:0] data_in;
    logic              prot_en;
    logic              busy;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              addr_err;
    logic              wr_fault;

    modport master (
        output read_en, write_en, base_address, offset_address, data_in, prot_en,
        input  busy, data_out, rd_valid, addr_err, wr_fault
    );

    modport slave (
        input  read_en, write_en, base_address, offset_address, data_in, prot_en,
        output busy, data_out, rd_valid, addr_err, wr_fault
    );
endinterface

// File: rtl/data_mem_init_seq.sv
// Post-reset clearing sequencer: walks init_ptr over every word, then hands over to S_RUN.
module data_mem_init_seq
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned PTR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    output logic [PTR_W-1:0] init_ptr_o,
    output logic             busy_o,
    output logic             done_o
);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    mem_state_e       state_q;
    logic [PTR_W-1:0] ptr_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_INIT;
            ptr_q   <= '0;
        end else if (state_q == S_INIT) begin
            if (ptr_q == LAST_PTR) begin
                state_q <= S_RUN;
                ptr_q   <= '0;
            end else begin
                ptr_q <= ptr_q + PTR_W'(1);
            end
        end
    end

    assign init_ptr_o = ptr_q;
    assign busy_o     = (state_q == S_INIT);
    assign done_o     = (state_q == S_RUN);

endmodule

// File: rtl/data_mem_rw.sv
// Synchronous-read data memory with base+offset addressing, post-reset clear and a write-protected region.
module data_mem_rw
    import data_mem_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned PROT_BASE = DEF_PROT_BASE
) (
    input  logic         clk,
    input  logic         reset,
    data_mem_rw_if.slave bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] ea;
    logic [PTR_W-1:0]  ea_idx;
    logic [PTR_W-1:0]  init_ptr;
    logic              init_busy;
    logic              run;
    logic              in_range;
    logic              prot_hit;
    logic              rd_req;
    logic              wr_req;
    logic              wr_ok;

    logic              mem_we;
    logic [PTR_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic [DATA_W-1:0] data_out_q;
    logic              rd_valid_q;
    logic              addr_err_q;
    logic              wr_fault_q;

    data_mem_init_seq #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_init_seq (
        .clk        (clk),
        .reset      (reset),
        .init_ptr_o (init_ptr),
        .busy_o     (init_busy),
        .done_o     (run)
    );

    // Effective address and access classification; range check outranks protection
    assign ea       = ADDR_W'(ea_wrap(32'(bus.base_address), 32'(bus.offset_address), ADDR_W));
    assign ea_idx   = PTR_W'(ea);
    assign in_range = (32'(ea) < DEPTH);
    assign prot_hit = bus.prot_en && (32'(ea) >= PROT_BASE);
    assign rd_req   = run && bus.read_en;
    assign wr_req   = run && bus.write_en;
    assign wr_ok    = wr_req && in_range && !prot_hit;

    // Single write port shared by the clearing sequencer and store traffic
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = ea_idx;
        mem_wdata = bus.data_in;
        if (init_busy) begin
            mem_we    = reset;
            mem_waddr = init_ptr;
            mem_wdata = '0;
        end else if (wr_ok) begin
            mem_we = reset;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Registered read path; the array read sees the pre-write word (read-first)
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
            wr_fault_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_req && in_range;
            addr_err_q <= (rd_req || wr_req) && !in_range;
            wr_fault_q <= wr_req && in_range && prot_hit;
            if (rd_req && in_range) begin
                data_out_q <= mem[ea_idx];
            end
        end
    end

    assign bus.busy     = init_busy;
    assign bus.data_out = data_out_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.addr_err = addr_err_q;
    assign bus.wr_fault = wr_fault_q;

endmodule

// File: doc/data_mem_rw.md
# data_mem_rw

Parametrised successor to the 8-bit scratch data memory: a single-port-address, synchronous-read data memory with base+offset effective-address generation, a post-reset clearing sequencer, and a write-protected constant region. Sits between the datapath's load/store unit and the register file. It serves `lb`/`sb` traffic with a one-cycle registered read and flags illegal accesses instead of silently corrupting memory.

## Interface
- `DATA_W`, 8, data word width in bits
- `ADDR_W`, 8, width of base, offset and effective address
- `DEPTH`, 256, number of words implemented; must satisfy DEPTH ≤ 2**ADDR_W
- `PROT_BASE`, 128, first word of the write-protected constant region (PROT_BASE ≤ DEPTH)
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-low reset
- `read_en`  in  1  read request this cycle
- `write_en`  in  1  write request this cycle
- `base_address`  in  ADDR_W  base register value
- `offset_address`  in  ADDR_W  displacement
- `data_in`  in  DATA_W  store data
- `prot_en`  in  1  1 = writes at ea ≥ PROT_BASE are blocked
- `busy`  out  1  high while clearing; requests ignored
- `data_out`  out  DATA_W  registered read data
- `rd_valid`  out  1  data_out holds result of previous-cycle read
- `addr_err`  out  1  one-cycle pulse: previous-cycle access had ea ≥ DEPTH
- `wr_fault`  out  1  one-cycle pulse: previous-cycle write blocked by protection

## Operation
- Effective address ea = (base_address + offset_address) mod 2**ADDR_W; the carry is discarded, e.g. 0xF0+0x20 = 0x10.
- States: S_INIT (clearing) and S_RUN.
- reset=0 at an edge → S_INIT, init_ptr=0, data_out=0, rd_valid=0, addr_err=0, wr_fault=0. busy is 1 combinationally while in S_INIT.
- S_INIT: each edge with reset=1 writes 0 to mem[init_ptr] and increments init_ptr. The edge that writes mem[DEPTH-1] moves to S_RUN. Protection does not apply to init writes.
- S_INIT: read_en/write_en are ignored and produce no flags.
- S_RUN read (read_en=1, ea < DEPTH): data_out ← mem[ea], rd_valid ← 1 at the next edge.
- S_RUN read with ea ≥ DEPTH: rd_valid ← 0, addr_err ← 1, data_out holds its previous value.
- S_RUN write with ea < DEPTH, and either prot_en=0 or ea < PROT_BASE: mem[ea] ← data_in.
- S_RUN write blocked by protection: memory unchanged, wr_fault ← 1.
- S_RUN write with ea ≥ DEPTH: memory unchanged, addr_err ← 1. The out-of-range check takes priority over the protection check.
- Simultaneous read_en and write_en at the same ea is read-first: data_out gets the old word, and the new word is visible on the following read.
- No request: rd_valid ← 0 and data_out holds. addr_err and wr_fault are pulses, cleared every edge unless re-set.

## Timing
- Read latency is 1 cycle: request at edge N, data and rd_valid valid after edge N+1. Back-to-back reads give one result per cycle.
- Write takes effect at the request edge and is visible to a read issued in the next cycle.
- busy deasserts exactly DEPTH edges after the first edge with reset=1.
- Reset asserted mid-clear or mid-operation: the sequence restarts from init_ptr=0 and any in-flight read result is dropped (rd_valid=0).
- All outputs are registered except busy, which decodes state.

## Structure
- Package `data_mem_pkg`:
  - state enum `mem_state_e` {S_INIT, S_RUN}
  - function for effective-address wrap
  - default parameter constants
- One sub-module, `data_mem_init_seq`: init_ptr counter, state register, busy and done generation. It drives a write-port mux in the top level.
- Top level contains:
  - storage array `logic [DATA_W-1:0] mem [DEPTH]`
  - ea adder
  - access checks
  - registered read path

## Test plan
- Reset low 2 cycles, then high: busy=1 for exactly 256 cycles, then 0. Reads of 0x00, 0x7F, 0xFF all return 0x00.
- Write 0xA5 at base 0x10, offset 0x05; read the same address next cycle: data_out=0xA5, rd_valid=1 one cycle after the read.
- Wrap: base 0xF0, offset 0x20, write 0x3C; read base 0x00, offset 0x10 → 0x3C.
- prot_en=1, write 0x77 to ea 0x80: wr_fault pulses once and a read of 0x80 returns 0x00. With prot_en=0 the same write succeeds.
- DEPTH=200, read ea 0xD0 (208): addr_err=1, rd_valid=0, data_out unchanged.
- Same-cycle read and write at 0x20 (old 0x11, new 0x22): data_out=0x11; next read returns 0x22. Reset mid-clear at init_ptr=50 restarts busy for a full 256 cycles.
